// File: rtl/micro_sequencer_if.sv
// ---------------------------------------------------------------------------
// micro_sequencer_if
//   Host-side bus of the micro-sequencer: table programming, run handshake,
//   and the register-bank / ALU control it drives while stepping a program.
//
//   master : host / test logic (drives programming and start, observes run)
//   slave  : micro_sequencer
//
//   prog_we/prog_addr/prog_data  table write port (ignored while busy)
//   start/len                    run request and instruction count
//   busy/done                    run status (done is a one-cycle pulse)
//   pc/step_count                current entry index / instructions executed
//   alu_op/rd_addr/rs1_addr/rs2_addr/reg_we   per-instruction control
// ---------------------------------------------------------------------------
interface micro_sequencer_if #(
  parameter int OP_W   = 4,
  parameter int REG_AW = 4,
  parameter int DEPTH  = 8
);
  localparam int PC_W = $clog2(DEPTH);
  localparam int UI_W = OP_W + 3 * REG_AW;

  logic              prog_we;
  logic [PC_W-1:0]   prog_addr;
  logic [UI_W-1:0]   prog_data;
  logic              start;
  logic [PC_W:0]     len;

  logic              busy;
  logic              done;
  logic [PC_W-1:0]   pc;
  logic [OP_W-1:0]   alu_op;
  logic [REG_AW-1:0] rd_addr;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              reg_we;
  logic [PC_W:0]     step_count;

  modport master (
    output prog_we, prog_addr, prog_data, start, len,
    input  busy, done, pc, alu_op, rd_addr, rs1_addr, rs2_addr, reg_we, step_count
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, len,
    output busy, done, pc, alu_op, rd_addr, rs1_addr, rs2_addr, reg_we, step_count
  );
endinterface

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
//   Steps through a writable table of micro-instructions {op, rd, rs1, rs2}
//   (MSB first). Each entry takes a FETCH cycle (load instruction register)
//   and an EXEC cycle (drive register addresses, ALU opcode and reg_we).
//   A run is started from IDLE with a length (clamped to DEPTH); an entry
//   whose op equals HALT_OP ends the run at FETCH without any write.
//
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (clears FSM, counters and table)
//   bus  : micro_sequencer_if.slave -- programming port, start/busy/done
//          handshake, and register-bank / ALU control outputs
// ---------------------------------------------------------------------------
module micro_sequencer #(
  parameter int              OP_W    = 4,
  parameter int              REG_AW  = 4,
  parameter int              DEPTH   = 8,
  parameter logic [OP_W-1:0] HALT_OP = '1
) (
  input  logic                clk,
  input  logic                rst,
  micro_sequencer_if.slave    bus
);
  localparam int PC_W = $clog2(DEPTH);
  localparam int UI_W = OP_W + 3 * REG_AW;
  localparam logic [PC_W:0] DEPTH_L = (PC_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W:0]     step_q, step_d;
  logic [PC_W:0]     len_q, len_d;
  logic [UI_W-1:0]   ir_q, ir_d;
  logic [UI_W-1:0]   table_q [DEPTH];

  logic [PC_W:0]     len_clamped;
  logic [UI_W-1:0]   fetch_word;
  logic [OP_W-1:0]   fetch_op;
  logic [OP_W-1:0]   ir_op;
  logic [PC_W:0]     step_inc;
  logic              busy_w;

  assign len_clamped = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
  assign fetch_word  = table_q[pc_q];
  assign fetch_op    = fetch_word[UI_W-1 -: OP_W];
  assign ir_op       = ir_q[UI_W-1 -: OP_W];
  assign step_inc    = step_q + 1'b1;
  assign busy_w      = (state_q == S_FETCH) || (state_q == S_EXEC);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      step_q  <= '0;
      len_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      step_q  <= step_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
    end
  end

  // Micro-instruction table. Writes are only accepted outside a run so the
  // program cannot change under the sequencer's feet.
  // NOTE: reset must clear every entry, so the table is a flop array with a
  // reset loop rather than an inferred RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (bus.prog_we && !busy_w) begin
      table_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets its hold value first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    step_d  = step_q;
    len_d   = len_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          step_d = '0;
          len_d  = len_clamped;
          if (len_clamped != '0) begin
            pc_d    = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        ir_d    = fetch_word;
        state_d = (fetch_op == HALT_OP) ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        step_d = step_inc;
        // len_q <= DEPTH, so pc only advances while another entry exists
        // and never wraps past DEPTH-1.
        if (step_inc == len_q) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    bus.busy       = busy_w;
    bus.done       = (state_q == S_DONE);
    bus.pc         = pc_q;
    bus.step_count = step_q;
    bus.alu_op     = '0;
    bus.rd_addr    = '0;
    bus.rs1_addr   = '0;
    bus.rs2_addr   = '0;
    bus.reg_we     = 1'b0;
    if (state_q == S_EXEC) begin
      bus.alu_op   = ir_op;
      bus.rd_addr  = ir_q[3*REG_AW-1 -: REG_AW];
      bus.rs1_addr = ir_q[2*REG_AW-1 -: REG_AW];
      bus.rs2_addr = ir_q[REG_AW-1:0];
      // Gated by rst so a reset edge never doubles as a register-bank write.
      bus.reg_we   = !rst && (ir_op != HALT_OP);
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer
//   Directed and randomized runs of micro_sequencer. Expected behaviour comes
//   from a table model and the run timing rules: entry k is fetched in cycle
//   2k+1 and executed in 2k+2; a run ends at the first HALT entry or after
//   min(len, DEPTH) entries.
// ---------------------------------------------------------------------------
module tb_micro_sequencer;
  localparam int OP_W   = 4;
  localparam int REG_AW = 4;
  localparam int DEPTH  = 8;
  localparam int PC_W   = $clog2(DEPTH);
  localparam int UI_W   = OP_W + 3 * REG_AW;
  localparam logic [OP_W-1:0] HALT = 4'hF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  micro_sequencer_if #(.OP_W(OP_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) bus ();

  micro_sequencer #(
    .OP_W(OP_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .HALT_OP(HALT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [UI_W-1:0] model_tbl [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = '0;
  endtask

  task automatic prog(input int addr, input logic [UI_W-1:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr[PC_W-1:0];
    bus.prog_data = data;
    tick();
    bus.prog_we   = 1'b0;
    model_tbl[addr] = data;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".busy"},   bus.busy, 0);
    chk({tag, ".done"},   bus.done, 0);
    chk({tag, ".pc"},     bus.pc, 0);
    chk({tag, ".alu_op"}, bus.alu_op, 0);
    chk({tag, ".rd"},     bus.rd_addr, 0);
    chk({tag, ".rs1"},    bus.rs1_addr, 0);
    chk({tag, ".rs2"},    bus.rs2_addr, 0);
    chk({tag, ".reg_we"}, bus.reg_we, 0);
    chk({tag, ".steps"},  bus.step_count, 0);
  endtask

  // One complete run starting in IDLE (cycle 0 = now). poke: hammer the
  // table, start and len during the run; co_write: program entry 0 in the
  // same cycle as start.
  task automatic run(input string tag, input int len_v, input bit poke,
                     input bit co_write, input logic [UI_W-1:0] co_data);
    int eff, n_exec, done_c, writes, k;
    bit halted;
    logic [UI_W-1:0] e;
    if (co_write) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = '0;
      bus.prog_data = co_data;
      model_tbl[0]  = co_data;
    end
    bus.start = 1'b1;
    bus.len   = len_v[PC_W:0];

    eff    = (len_v > DEPTH) ? DEPTH : len_v;
    n_exec = 0;
    halted = 1'b0;
    for (int i = 0; i < eff; i++) begin
      if (model_tbl[i][UI_W-1 -: OP_W] == HALT) begin
        halted = 1'b1;
        break;
      end
      n_exec++;
    end
    done_c = halted ? 2 * n_exec + 2 : 2 * n_exec + 1;
    writes = 0;

    tick();
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    for (int c = 1; c <= done_c; c++) begin
      if (c == done_c) begin
        chk({tag, ".done"},   bus.done, 1);
        chk({tag, ".busy"},   bus.busy, 0);
        chk({tag, ".reg_we"}, bus.reg_we, 0);
        chk({tag, ".alu_op"}, bus.alu_op, 0);
        chk({tag, ".steps"},  bus.step_count, n_exec);
      end else if (c % 2 == 0) begin
        k = (c - 2) / 2;
        e = model_tbl[k];
        chk({tag, ".x.busy"},   bus.busy, 1);
        chk({tag, ".x.done"},   bus.done, 0);
        chk({tag, ".x.reg_we"}, bus.reg_we, 1);
        chk({tag, ".x.pc"},     bus.pc, k);
        chk({tag, ".x.alu_op"}, bus.alu_op, e[15:12]);
        chk({tag, ".x.rd"},     bus.rd_addr, e[11:8]);
        chk({tag, ".x.rs1"},    bus.rs1_addr, e[7:4]);
        chk({tag, ".x.rs2"},    bus.rs2_addr, e[3:0]);
        chk({tag, ".x.steps"},  bus.step_count, k);
      end else begin
        k = (c - 1) / 2;
        chk({tag, ".f.busy"},   bus.busy, 1);
        chk({tag, ".f.reg_we"}, bus.reg_we, 0);
        chk({tag, ".f.pc"},     bus.pc, k);
        chk({tag, ".f.alu_op"}, bus.alu_op, 0);
        chk({tag, ".f.steps"},  bus.step_count, k);
      end
      if (bus.reg_we === 1'b1) writes++;
      // Writes and restarts while busy must be ignored; the table write
      // is dropped before DONE, where it would be honoured.
      if (poke && c < done_c) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = 3'd2;
        bus.prog_data = UI_W'($urandom);
        bus.start     = 1'b1;
        bus.len       = PC_W'($urandom) + 1'b1;
      end else begin
        bus.prog_we = 1'b0;
        bus.start   = poke && (c == done_c);
      end
      tick();
    end
    bus.start = 1'b0;
    chk({tag, ".after.busy"},  bus.busy, 0);
    chk({tag, ".after.done"},  bus.done, 0);
    chk({tag, ".after.steps"}, bus.step_count, n_exec);
    chk({tag, ".writes"},      writes, n_exec);
  endtask

  initial begin
    logic [UI_W-1:0] w;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;
    bus.len       = '0;
    rst           = 1'b1;
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    chk_idle_zero("reset");

    // 1. three-entry program
    prog(0, 16'h0123);
    prog(1, 16'h1415);
    prog(2, 16'hA212);
    run("t1", 3, 1'b0, 1'b0, '0);

    // 2. HALT at entry 1
    prog(1, 16'hF000);
    run("t2", 4, 1'b0, 1'b0, '0);

    // 3. zero length
    run("t3", 0, 1'b0, 1'b0, '0);

    // 4. full table, len clamps to DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      w = UI_W'($urandom);
      w[15:12] = 4'($urandom_range(0, 14));
      prog(i, w);
    end
    run("t4", 12, 1'b0, 1'b0, '0);

    // 6. writes and starts during a run are ignored; re-run shows entry 2 intact
    run("t6a", 4, 1'b1, 1'b0, '0);
    run("t6b", 4, 1'b0, 1'b0, '0);

    // write and start in the same IDLE cycle: run uses the new entry 0
    run("cowr", 2, 1'b0, 1'b1, 16'h7654);

    // 5. reset during the second EXEC
    bus.start = 1'b1;
    bus.len   = 4'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("t5.exec2.reg_we", bus.reg_we, 1);
    rst = 1'b1;
    #1;
    chk("t5.rst.reg_we", bus.reg_we, 0);
    tick();
    rst = 1'b0;
    model_clear();
    chk_idle_zero("t5.after");
    run("t5.len1", 1, 1'b0, 1'b0, '0);

    // randomized programs, lengths and interference
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          w = UI_W'($urandom);
          if ($urandom_range(0, 5) == 0) w[15:12] = HALT;
          else if (w[15:12] == HALT) w[15:12] = 4'h0;
          prog(i, w);
        end
      end
      run("rnd", $urandom_range(0, 15), 1'($urandom), 1'($urandom), UI_W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
